// File: rtl/mem_arbiter.sv
// Three-way memory bus arbiter: data (D) > fetch (I) > external (X), with X promoted after
// STARVE_LIMIT consecutive D/I grants. Define ARB_TIMEOUT_EN to enable the response timeout.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [31:0]       i_rdata_o,
  output logic              i_valid_o,

  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic [31:0]       d_rdata_o,
  output logic              d_valid_o,

  input  logic              x_req_i,
  input  logic              x_we_i,
  input  logic [ADDR_W-1:0] x_addr_i,
  input  logic [31:0]       x_wdata_i,
  output logic [31:0]       x_rdata_o,
  output logic              x_valid_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_valid_i,

  output logic              err_o,
  output logic [1:0]        owner_o
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : gen_bad_param
    $error("mem_arbiter: STARVE_LIMIT must be 1..15 and TIMEOUT 1..255");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnI    = 2'd1,
    OwnD    = 2'd2,
    OwnX    = 2'd3
  } owner_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  state_e              state_q;
  owner_e              owner_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic [3:0]          starve_q, starve_d;

  owner_e              win;
  logic                mem_done;
  logic                tmo_hit;
  logic                finish;
  logic [31:0]         rsp_data;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TmoMax = 8'(TIMEOUT);
  logic [7:0] tmo_q;
  assign tmo_hit = (state_q == StBusy) && !mem_valid_i && (tmo_q == TmoMax);
`else
  assign tmo_hit = 1'b0;
`endif

  // Winner and starvation bookkeeping only matter at an IDLE grant edge.
  always_comb begin
    win = OwnNone;
    if ((starve_q == StarveMax) && x_req_i) begin
      win = OwnX;
    end else if (d_req_i) begin
      win = OwnD;
    end else if (i_req_i) begin
      win = OwnI;
    end else if (x_req_i) begin
      win = OwnX;
    end

    starve_d = starve_q;
    if ((win == OwnX) || !x_req_i) begin
      starve_d = 4'd0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // A real memory response always wins over a coincident timeout.
  assign mem_done = (state_q == StBusy) && mem_valid_i;
  assign finish   = mem_done || tmo_hit;
  assign rsp_data = mem_valid_i ? mem_rdata_i : 32'hFFFF_FFFF;

  always_comb begin
    i_valid_o = finish && (owner_q == OwnI);
    d_valid_o = finish && (owner_q == OwnD);
    x_valid_o = finish && (owner_q == OwnX);
    i_rdata_o = i_valid_o ? rsp_data : 32'd0;
    d_rdata_o = d_valid_o ? rsp_data : 32'd0;
    x_rdata_o = x_valid_o ? rsp_data : 32'd0;
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign owner_o     = owner_q;
  assign err_o       = tmo_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      owner_q     <= OwnNone;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      starve_q    <= 4'd0;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= 8'd0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win != OwnNone) begin
            state_q   <= StBusy;
            owner_q   <= win;
            mem_req_q <= 1'b1;
            starve_q  <= starve_d;
`ifdef ARB_TIMEOUT_EN
            tmo_q     <= 8'd0;
`endif
            unique case (win)
              OwnI: begin
                mem_we_q    <= 1'b0;
                mem_addr_q  <= i_addr_i;
                mem_wdata_q <= 32'd0;
              end
              OwnD: begin
                mem_we_q    <= d_we_i;
                mem_addr_q  <= d_addr_i;
                mem_wdata_q <= d_wdata_i;
              end
              OwnX: begin
                mem_we_q    <= x_we_i;
                mem_addr_q  <= x_addr_i;
                mem_wdata_q <= x_wdata_i;
              end
              default: ;
            endcase
          end
        end
        StBusy: begin
          if (finish) begin
            state_q   <= StDone;
            owner_q   <= OwnNone;
            mem_req_q <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            tmo_q <= tmo_q + 8'd1;
          end
`endif
        end
        // Dead cycle lets the finished requester drop REQ before the next arbitration.
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, all checked every cycle
// against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  localparam int unsigned AW    = 32;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned TMO   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          rq_req   [1:3];
  logic          rq_we    [1:3];
  logic [AW-1:0] rq_addr  [1:3];
  logic [31:0]   rq_wdata [1:3];
  logic          mem_valid;
  logic [31:0]   mem_rdata;

  logic [31:0]   i_rdata, d_rdata, x_rdata;
  logic          i_valid, d_valid, x_valid;
  logic          mem_req, mem_we, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [1:0]    owner;

  mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_req_i(rq_req[1]), .i_addr_i(rq_addr[1]), .i_rdata_o(i_rdata), .i_valid_o(i_valid),
    .d_req_i(rq_req[2]), .d_we_i(rq_we[2]), .d_addr_i(rq_addr[2]), .d_wdata_i(rq_wdata[2]),
    .d_rdata_o(d_rdata), .d_valid_o(d_valid),
    .x_req_i(rq_req[3]), .x_we_i(rq_we[3]), .x_addr_i(rq_addr[3]), .x_wdata_i(rq_wdata[3]),
    .x_rdata_o(x_rdata), .x_valid_o(x_valid),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_valid_i(mem_valid),
    .err_o(err), .owner_o(owner)
  );

  // Transaction-level model: current owner (0 = none), dead-cycle flag, captured request.
  int            m_owner, m_starve, m_tmo;
  bit            m_dead, m_fin;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;

  int  lat, lat_cfg;
  bit  lat_rand, mem_hang, stray_en, prev_req;
  int  vld_cnt [1:3];
  bit  seen_vld [1:3];
  int  err_seen;
  int  glog [$];
  int  n_err, n_checks;

  function automatic logic obs_valid(int r);
    case (r)
      1: return i_valid;
      2: return d_valid;
      default: return x_valid;
    endcase
  endfunction

  function automatic logic [31:0] obs_rdata(int r);
    case (r)
      1: return i_rdata;
      2: return d_rdata;
      default: return x_rdata;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit busy, hit, ev;
    logic [31:0] er;
    busy = (m_owner != 0);
    hit  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hit = busy && !mem_valid && (m_tmo == TMO);
`endif
    m_fin = busy && (mem_valid || hit);
    chk("mem_req", mem_req, busy);
    chk("owner", owner, m_owner);
    if (busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    for (int r = 1; r <= 3; r++) begin
      ev = m_fin && (m_owner == r);
      er = ev ? (mem_valid ? mem_rdata : 32'hFFFF_FFFF) : 32'd0;
      chk($sformatf("valid%0d", r), obs_valid(r), ev);
      chk($sformatf("rdata%0d", r), obs_rdata(r), er);
      seen_vld[r] = obs_valid(r);
      if (obs_valid(r)) vld_cnt[r]++;
    end
    chk("err", err, hit);
    if (err) err_seen++;
    if (mem_req && !prev_req) glog.push_back(int'(owner));
    prev_req = mem_req;
  endtask

  task automatic model_edge();
    int w;
    if (m_owner != 0) begin
      if (m_fin) begin
        m_owner = 0;
        m_dead  = 1'b1;
      end else begin
        m_tmo++;
      end
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else if (rq_req[1] || rq_req[2] || rq_req[3]) begin
      if (m_starve == LIMIT && rq_req[3]) w = 3;
      else if (rq_req[2]) w = 2;
      else if (rq_req[1]) w = 1;
      else w = 3;
      if (w == 3 || !rq_req[3]) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      m_owner = w;
      m_addr  = rq_addr[w];
      m_we    = (w == 1) ? 1'b0 : rq_we[w];
      m_wdata = (w == 1) ? 32'd0 : rq_wdata[w];
      m_tmo   = 0;
      lat     = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
    end
  endtask

  // Requesters drop REQ after their VALID; memory answers after `lat` busy cycles.
  task automatic agents();
    for (int r = 1; r <= 3; r++) begin
      if (seen_vld[r]) begin
        rq_req[r]   = 1'b0;
        seen_vld[r] = 1'b0;
      end
    end
    if (m_owner != 0 && !mem_hang) begin
      if (lat == 0) begin
        mem_valid = 1'b1;
        mem_rdata = $urandom;
      end else begin
        lat--;
        mem_valid = 1'b0;
      end
    end else begin
      mem_valid = stray_en && ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
    agents();
  endtask

  task automatic raise(int r, logic we, logic [AW-1:0] addr, logic [31:0] wdata);
    rq_req[r]   = 1'b1;
    rq_we[r]    = we;
    rq_addr[r]  = addr;
    rq_wdata[r] = wdata;
  endtask

  task automatic run_until(int r, int budget);
    int start;
    start = vld_cnt[r];
    for (int k = 0; k < budget && vld_cnt[r] == start; k++) step();
    chk($sformatf("valid_pulse%0d", r), vld_cnt[r] - start, 1);
  endtask

  task automatic feed_di();
    if (!rq_req[2]) raise(2, 1'b1, $urandom, $urandom);
    if (!rq_req[1]) raise(1, 1'b0, $urandom, 32'd0);
  endtask

  initial begin
    int i0, d0, x0, e0, nx;
    rst_n = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      rq_req[r] = 1'b0; rq_we[r] = 1'b0; rq_addr[r] = '0; rq_wdata[r] = 32'd0;
      vld_cnt[r] = 0; seen_vld[r] = 1'b0;
    end
    mem_valid = 1'b0; mem_rdata = 32'd0;
    m_owner = 0; m_starve = 0; m_tmo = 0; m_dead = 1'b0; m_fin = 1'b0;
    m_we = 1'b0; m_addr = '0; m_wdata = 32'd0;
    lat = 0; lat_cfg = 2; lat_rand = 1'b0; mem_hang = 1'b0; stray_en = 1'b0; prev_req = 1'b0;
    err_seen = 0; n_err = 0; n_checks = 0;

    // Reset state
    @(posedge clk);
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_valids", {i_valid, d_valid, x_valid}, 0);
    chk("rst_err", err, 0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch, memory answers two cycles after MEM_REQ
    glog.delete();
    raise(1, 1'b1, 32'h100, 32'h1234);
    lat_cfg = 2;
    run_until(1, 20);
    chk("fetch_done_owner", owner, 0);
    chk("fetch_done_mem_req", mem_req, 0);
    repeat (3) step();
    chk("fetch_grants", glog.size(), 1);
    if (glog.size() > 0) chk("fetch_owner", glog[0], 1);

    // Conflict: D and I raised together
    glog.delete();
    i0 = vld_cnt[1]; d0 = vld_cnt[2];
    raise(1, 1'b0, 32'h104, 32'd0);
    raise(2, 1'b1, 32'h2000, 32'hDEADBEEF);
    lat_cfg = 1;
    for (int k = 0; k < 40 && (vld_cnt[1] == i0 || vld_cnt[2] == d0); k++) step();
    repeat (4) step();
    chk("conflict_grants", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("conflict_first", glog[0], 2);
      chk("conflict_second", glog[1], 1);
    end
    chk("conflict_d_pulses", vld_cnt[2] - d0, 1);
    chk("conflict_i_pulses", vld_cnt[1] - i0, 1);

    // Starvation: X waits behind continuous D/I traffic, twice in a row
    lat_cfg = 0;
    for (int round = 0; round < 2; round++) begin
      glog.delete();
      x0 = vld_cnt[3];
      raise(3, 1'b1, 32'hC000 + 32'(round), 32'hA5A5_0000 + 32'(round));
      for (int k = 0; k < 100 && vld_cnt[3] == x0; k++) begin
        feed_di();
        step();
      end
      nx = 0;
      for (int j = 0; j < 4 && j < glog.size(); j++) if (glog[j] == 3) nx++;
      chk($sformatf("starve_len%0d", round), glog.size() >= 5, 1);
      chk($sformatf("starve_early_x%0d", round), nx, 0);
      if (glog.size() >= 5) chk($sformatf("starve_x_at5_%0d", round), glog[4], 3);
    end
    for (int k = 0; k < 40 && (rq_req[1] || rq_req[2]); k++) step();
    repeat (3) step();

    // Reset mid-transaction, between clock edges
    mem_hang = 1'b1;
    glog.delete();
    raise(1, 1'b0, 32'h300, 32'd0);
    step();
    step();
    chk("pre_rst_busy", mem_req, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_owner", owner, 0);
    m_owner = 0; m_dead = 1'b0; m_starve = 0; m_tmo = 0;
    mem_valid = 1'b0; prev_req = 1'b0;
    #1 rst_n = 1'b1;
    mem_hang = 1'b0;
    lat_cfg = 1;
    run_until(1, 20);
    chk("rst_regrant_count", glog.size(), 2);
    if (glog.size() >= 2) chk("rst_regrant_owner", glog[1], 1);
    repeat (2) step();

    // Withdrawal: D drops REQ one cycle after grant
    lat_cfg = 3;
    glog.delete();
    raise(2, 1'b0, 32'h400, 32'd0);
    step();
    step();
    rq_req[2] = 1'b0;
    run_until(2, 20);
    repeat (4) step();
    chk("withdraw_grants", glog.size(), 1);

    // Memory never answers
    mem_hang = 1'b1;
    i0 = vld_cnt[1];
    e0 = err_seen;
    raise(1, 1'b0, 32'h500, 32'd0);
    repeat (30) step();
`ifdef ARB_TIMEOUT_EN
    chk("tmo_err_pulses", err_seen - e0, 1);
    chk("tmo_valid_pulses", vld_cnt[1] - i0, 1);
`else
    chk("hang_mem_req", mem_req, 1);
    chk("hang_no_valid", vld_cnt[1] - i0, 0);
    chk("hang_no_err", err_seen - e0, 0);
`endif
    mem_hang = 1'b0;
    for (int k = 0; k < 20 && rq_req[1]; k++) step();
    repeat (3) step();

    // Random traffic with random latency and stray MEM_VALID pulses while idle
    lat_rand = 1'b1;
    stray_en = 1'b1;
    repeat (1500) begin
      for (int r = 1; r <= 3; r++) begin
        if (!rq_req[r] && $urandom_range(0, 3) == 0) raise(r, 1'($urandom), $urandom, $urandom);
      end
      step();
    end
    stray_en = 1'b0;
    for (int k = 0; k < 200 && (rq_req[1] || rq_req[2] || rq_req[3]); k++) step();
    repeat (3) step();
    chk("drain_idle", mem_req, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
